// File: rtl/write_data.sv
// write_data: receive side of the pixel-pair stream. Each accepted even/odd
// RGB pair is written as one 48-bit word into a frame memory. Rows are
// stored bottom-up, so row 0 of the stream lands at the highest row base
// address. The block also reports frame completion, overrun and short-frame
// conditions through sticky flags.
module write_data #(
  parameter int IMAGE_WIDTH   = 768,
  parameter int IMAGE_HEIGHT  = 512,
  parameter int ADDRESS_WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vertical_Pulse,
  input  logic                     horizontal_Pulse,
  input  logic [7:0]               data_R_Even,
  input  logic [7:0]               data_G_Even,
  input  logic [7:0]               data_B_Even,
  input  logic [7:0]               data_R_Odd,
  input  logic [7:0]               data_G_Odd,
  input  logic [7:0]               data_B_Odd,
  output logic                     mem_Write_Enable,
  output logic [ADDRESS_WIDTH-1:0] mem_Address,
  output logic [47:0]              mem_Data,
  output logic                     done_Flag,
  output logic                     overrun_Error,
  output logic                     short_Frame_Error
);

  localparam int PAIRS_PER_ROW = IMAGE_WIDTH / 2;
  localparam int COL_W = (PAIRS_PER_ROW > 1) ? $clog2(PAIRS_PER_ROW) : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PAIRS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

  // Where the counters land after the very first pair of a frame has been
  // taken in the start-of-frame cycle itself.
  localparam logic [COL_W-1:0] FIRST_NEXT_COL = (PAIRS_PER_ROW > 1) ? COL_W'(1) : '0;
  localparam logic [ROW_W-1:0] FIRST_NEXT_ROW = (PAIRS_PER_ROW > 1) ? '0 : ROW_W'(1);
  localparam bit               FIRST_IS_LAST  = (PAIRS_PER_ROW == 1) && (IMAGE_HEIGHT == 1);

  // Stream row 0, column 0 sits at the base of the bottom-most stored row.
  localparam logic [ADDRESS_WIDTH-1:0] FIRST_ADDR =
    ADDRESS_WIDTH'((IMAGE_HEIGHT - 1) * PAIRS_PER_ROW);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                   state;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic                     v_pulse_q;

  logic                     sof;
  logic                     beat;
  logic                     end_of_row;
  logic                     end_of_frame;
  logic [ADDRESS_WIDTH-1:0] row_base;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [47:0]              pixel_word;

  // Decode framing events and the bottom-up address of the current pair.
  always_comb begin
    // NOTE: every signal gets a value on every path through this block, so
    // no latch is inferred; here all assignments are unconditional.
    sof          = vertical_Pulse & ~v_pulse_q;
    beat         = horizontal_Pulse & (state == RECEIVE);
    end_of_row   = (col == COL_LAST);
    end_of_frame = end_of_row & (row == ROW_LAST);
    row_base     = ADDRESS_WIDTH'(IMAGE_HEIGHT - 1) - ADDRESS_WIDTH'(row);
    cur_addr     = row_base * ADDRESS_WIDTH'(PAIRS_PER_ROW) + ADDRESS_WIDTH'(col);
    pixel_word   = {data_R_Odd, data_G_Odd, data_B_Odd,
                    data_R_Even, data_G_Even, data_B_Even};
  end

  // Frame FSM, pair counters, sticky flags and the registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the write port is plain output registers, not a memory array,
      // so all of it is reset; this also drops any strobe in flight.
      state             <= IDLE;
      col               <= '0;
      row               <= '0;
      v_pulse_q         <= 1'b0;
      mem_Write_Enable  <= 1'b0;
      mem_Address       <= '0;
      mem_Data          <= '0;
      done_Flag         <= 1'b0;
      overrun_Error     <= 1'b0;
      short_Frame_Error <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value regardless of statement order.
      v_pulse_q        <= vertical_Pulse;
      mem_Write_Enable <= 1'b0;

      if (sof && !(beat && end_of_frame)) begin
        // Start of frame wins over an ordinary beat. An unfinished frame
        // in progress is reported as short.
        short_Frame_Error <= (state == RECEIVE);
        overrun_Error     <= 1'b0;
        done_Flag         <= 1'b0;
        if (horizontal_Pulse) begin
          // The pair arriving with the start pulse is pair 0 of the new frame.
          mem_Write_Enable <= 1'b1;
          mem_Address      <= FIRST_ADDR;
          mem_Data         <= pixel_word;
          if (FIRST_IS_LAST) begin
            state     <= DONE;
            done_Flag <= 1'b1;
            col       <= '0;
            row       <= '0;
          end else begin
            state <= RECEIVE;
            col   <= FIRST_NEXT_COL;
            row   <= FIRST_NEXT_ROW;
          end
        end else begin
          state <= RECEIVE;
          col   <= '0;
          row   <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
          end

          RECEIVE: begin
            if (beat) begin
              mem_Write_Enable <= 1'b1;
              mem_Address      <= cur_addr;
              mem_Data         <= pixel_word;
              if (end_of_frame) begin
                col <= '0;
                row <= '0;
                // A start pulse alongside the completing pair re-arms for the
                // next frame directly instead of parking in DONE.
                if (sof) begin
                  state     <= RECEIVE;
                  done_Flag <= 1'b0;
                end else begin
                  state     <= DONE;
                  done_Flag <= 1'b1;
                end
              end else if (end_of_row) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end

          DONE: begin
            if (horizontal_Pulse) begin
              overrun_Error <= 1'b1;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_write_data.sv
// Self-checking bench for write_data with an 8x4 image (4 pairs per row,
// 16 pairs per frame). A count-based reference model predicts the write
// port and flags for every cycle.
module tb_write_data;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int AW    = 18;
  localparam int PPR   = W / 2;
  localparam int TOTAL = PPR * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          vertical_Pulse;
  logic          horizontal_Pulse;
  logic [7:0]    data_R_Even, data_G_Even, data_B_Even;
  logic [7:0]    data_R_Odd, data_G_Odd, data_B_Odd;
  logic          mem_Write_Enable;
  logic [AW-1:0] mem_Address;
  logic [47:0]   mem_Data;
  logic          done_Flag;
  logic          overrun_Error;
  logic          short_Frame_Error;

  always #5 clk = ~clk;

  write_data #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .vertical_Pulse   (vertical_Pulse),
    .horizontal_Pulse (horizontal_Pulse),
    .data_R_Even      (data_R_Even),
    .data_G_Even      (data_G_Even),
    .data_B_Even      (data_B_Even),
    .data_R_Odd       (data_R_Odd),
    .data_G_Odd       (data_G_Odd),
    .data_B_Odd       (data_B_Odd),
    .mem_Write_Enable (mem_Write_Enable),
    .mem_Address      (mem_Address),
    .mem_Data         (mem_Data),
    .done_Flag        (done_Flag),
    .overrun_Error    (overrun_Error),
    .short_Frame_Error(short_Frame_Error)
  );

  int tests = 0;
  int fails = 0;

  // Addresses of one full frame in arrival order: bottom row first.
  int exp_seq[16] = '{12, 13, 14, 15, 8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};

  // Reference model: frame phase, pairs taken so far, expected outputs.
  int            m_mode;  // 0 waiting for first frame, 1 receiving, 2 frame complete
  int            m_n;
  bit            m_vprev;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [47:0]   exp_data;
  logic          exp_done, exp_over, exp_short;

  logic [69:0] dut_obs, mdl_obs;
  assign dut_obs = {mem_Write_Enable, mem_Address, mem_Data,
                    done_Flag, overrun_Error, short_Frame_Error};
  assign mdl_obs = {exp_we, exp_addr, exp_data, exp_done, exp_over, exp_short};

  function automatic logic [AW-1:0] pair_addr(input int idx);
    return AW'((H - 1 - idx / PPR) * PPR + idx % PPR);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_vprev = 1'b0;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    exp_done = 1'b0; exp_over = 1'b0; exp_short = 1'b0;
  endtask

  task automatic model_write(input int idx, input logic [47:0] w);
    exp_we = 1'b1; exp_addr = pair_addr(idx); exp_data = w;
  endtask

  task automatic model_step(input logic v, input logic h, input logic [47:0] w);
    bit sof;
    sof    = v && !m_vprev;
    exp_we = 1'b0;
    if (m_mode == 1 && h && sof && m_n == TOTAL - 1) begin
      model_write(m_n, w);
      m_n = 0; exp_done = 1'b0;
    end else if (sof) begin
      exp_short = (m_mode == 1);
      exp_over  = 1'b0;
      exp_done  = 1'b0;
      m_mode    = 1;
      m_n       = 0;
      if (h) begin
        model_write(0, w);
        m_n = 1;
      end
    end else if (m_mode == 1 && h) begin
      model_write(m_n, w);
      m_n++;
      if (m_n == TOTAL) begin
        m_mode = 2; m_n = 0; exp_done = 1'b1;
      end
    end else if (m_mode == 2 && h) begin
      exp_over = 1'b1;
    end
    m_vprev = v;
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after rising.
  task automatic drive(input logic v, input logic h, input logic [47:0] w);
    @(negedge clk);
    vertical_Pulse   = v;
    horizontal_Pulse = h;
    {data_R_Odd, data_G_Odd, data_B_Odd, data_R_Even, data_G_Even, data_B_Even} = w;
    model_step(v, h, w);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset            = 1'b0;
    vertical_Pulse   = 1'b0;
    horizontal_Pulse = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [47:0] rand_word();
    return 48'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; vertical_Pulse = 1'b1; horizontal_Pulse = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (dut_obs !== '0) begin
        fails++;
        $display("FAIL reset cycle %0d: outputs %h, want 0", i, dut_obs);
      end
    end
    @(negedge clk);
    vertical_Pulse = 1'b0; horizontal_Pulse = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_full_frame();
    int got[$];
    drive(0, 0, '0);
    drive(1, 0, '0);
    for (int k = 0; k < TOTAL; k++) begin
      drive(1, 1, 48'(k));
      if (mem_Write_Enable === 1'b1) got.push_back(int'(mem_Address));
      tests++;
      if (dut_obs !== mdl_obs) begin
        fails++;
        $display("FAIL full_frame beat %0d: got %h want %h", k, dut_obs, mdl_obs);
      end
      if (k == TOTAL - 2) begin
        tests++;
        if (done_Flag !== 1'b0) begin
          fails++; $display("FAIL full_frame early done: got %b want 0", done_Flag);
        end
      end
    end
    tests++;
    if (done_Flag !== 1'b1) begin
      fails++; $display("FAIL full_frame done: got %b want 1", done_Flag);
    end
    tests++;
    if (got.size() != TOTAL) begin
      fails++; $display("FAIL full_frame write count: got %0d want %0d", got.size(), TOTAL);
    end
    for (int i = 0; i < got.size() && i < TOTAL; i++) begin
      tests++;
      if (got[i] != exp_seq[i]) begin
        fails++; $display("FAIL full_frame addr[%0d]: got %0d want %0d", i, got[i], exp_seq[i]);
      end
    end
    drive(1, 0, '0);
    tests++;
    if (dut_obs !== mdl_obs) begin
      fails++; $display("FAIL full_frame idle: got %h want %h", dut_obs, mdl_obs);
    end
  endtask

  task automatic test_gapped();
    int got[$];
    int beats = 0;
    drive(0, 0, '0);
    drive(1, 0, '0);
    while (beats < TOTAL) begin
      logic h;
      h = (beats == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(1, h, rand_word());
      if (h) beats++;
      if (mem_Write_Enable === 1'b1) got.push_back(int'(mem_Address));
      tests++;
      if (dut_obs !== mdl_obs) begin
        fails++;
        $display("FAIL gapped beat %0d h=%b: got %h want %h", beats, h, dut_obs, mdl_obs);
      end
      drive(1, 0, rand_word());
      tests++;
      if (dut_obs !== mdl_obs) begin
        fails++; $display("FAIL gapped gap after %0d: got %h want %h", beats, dut_obs, mdl_obs);
      end
    end
    tests++;
    if (done_Flag !== 1'b1) begin
      fails++; $display("FAIL gapped done: got %b want 1", done_Flag);
    end
    for (int i = 0; i < got.size() && i < TOTAL; i++) begin
      tests++;
      if (got[i] != exp_seq[i]) begin
        fails++; $display("FAIL gapped addr[%0d]: got %0d want %0d", i, got[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_data_packing();
    apply_reset();
    drive(1, 0, '0);
    @(negedge clk);
    horizontal_Pulse = 1'b1;
    data_R_Even = 8'h11; data_G_Even = 8'h22; data_B_Even = 8'h33;
    data_R_Odd  = 8'h44; data_G_Odd  = 8'h55; data_B_Odd  = 8'h66;
    model_step(1'b1, 1'b1, 48'h445566112233);
    @(posedge clk); #1;
    tests++;
    if (mem_Data !== 48'h445566112233) begin
      fails++; $display("FAIL packing data: got %h want 445566112233", mem_Data);
    end
    tests++;
    if (mem_Address !== AW'(12) || mem_Write_Enable !== 1'b1) begin
      fails++; $display("FAIL packing addr: got we=%b %0d want we=1 12", mem_Write_Enable, mem_Address);
    end
  endtask

  task automatic test_overrun();
    int writes = 0;
    apply_reset();
    drive(1, 0, '0);
    for (int k = 0; k < TOTAL + 1; k++) begin
      drive(1, 1, rand_word());
      if (mem_Write_Enable === 1'b1) writes++;
      tests++;
      if (dut_obs !== mdl_obs) begin
        fails++; $display("FAIL overrun beat %0d: got %h want %h", k, dut_obs, mdl_obs);
      end
    end
    tests++;
    if (writes != TOTAL || overrun_Error !== 1'b1 || done_Flag !== 1'b1) begin
      fails++;
      $display("FAIL overrun flags: writes=%0d ovr=%b done=%b want 16 1 1", writes, overrun_Error, done_Flag);
    end
    drive(0, 0, '0);
    drive(1, 0, '0);
    tests++;
    if (overrun_Error !== 1'b0 || done_Flag !== 1'b0) begin
      fails++; $display("FAIL overrun clear: ovr=%b done=%b want 0 0", overrun_Error, done_Flag);
    end
  endtask

  task automatic test_short_frame();
    apply_reset();
    drive(1, 0, '0);
    for (int k = 0; k < 6; k++) drive(1, 1, rand_word());
    tests++;
    if (short_Frame_Error !== 1'b0) begin
      fails++; $display("FAIL short early flag: got %b want 0", short_Frame_Error);
    end
    drive(0, 0, '0);
    drive(1, 0, '0);
    tests++;
    if (short_Frame_Error !== 1'b1) begin
      fails++; $display("FAIL short flag: got %b want 1", short_Frame_Error);
    end
    for (int k = 0; k < TOTAL; k++) begin
      drive(1, 1, rand_word());
      if (k == 0) begin
        tests++;
        if (mem_Address !== AW'(12)) begin
          fails++; $display("FAIL short first addr: got %0d want 12", mem_Address);
        end
      end
      tests++;
      if (dut_obs !== mdl_obs) begin
        fails++; $display("FAIL short beat %0d: got %h want %h", k, dut_obs, mdl_obs);
      end
    end
    tests++;
    if (done_Flag !== 1'b1) begin
      fails++; $display("FAIL short done: got %b want 1", done_Flag);
    end
  endtask

  task automatic test_sof_with_beat();
    apply_reset();
    drive(1, 0, '0);
    for (int k = 0; k < 5; k++) drive(1, 1, rand_word());
    drive(0, 0, '0);
    drive(1, 1, rand_word());
    tests++;
    if (mem_Write_Enable !== 1'b1 || mem_Address !== AW'(12) || short_Frame_Error !== 1'b1) begin
      fails++;
      $display("FAIL sof_beat: we=%b addr=%0d short=%b want 1 12 1", mem_Write_Enable, mem_Address, short_Frame_Error);
    end
    drive(1, 1, rand_word());
    tests++;
    if (mem_Address !== AW'(13)) begin
      fails++; $display("FAIL sof_beat next addr: got %0d want 13", mem_Address);
    end
    tests++;
    if (dut_obs !== mdl_obs) begin
      fails++; $display("FAIL sof_beat model: got %h want %h", dut_obs, mdl_obs);
    end
  endtask

  task automatic test_complete_with_sof();
    apply_reset();
    drive(1, 0, '0);
    for (int k = 0; k < TOTAL - 2; k++) drive(1, 1, rand_word());
    drive(0, 1, rand_word());
    drive(1, 1, rand_word());
    tests++;
    if (mem_Write_Enable !== 1'b1 || mem_Address !== AW'(3) || done_Flag !== 1'b0 ||
        short_Frame_Error !== 1'b0) begin
      fails++;
      $display("FAIL complete_sof: we=%b addr=%0d done=%b short=%b want 1 3 0 0",
               mem_Write_Enable, mem_Address, done_Flag, short_Frame_Error);
    end
    drive(1, 1, rand_word());
    tests++;
    if (mem_Address !== AW'(12) || dut_obs !== mdl_obs) begin
      fails++; $display("FAIL complete_sof next: got %h want %h", dut_obs, mdl_obs);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    drive(1, 0, '0);
    for (int k = 0; k < 5; k++) drive(1, 1, rand_word());
    tests++;
    if (mem_Write_Enable !== 1'b1) begin
      fails++; $display("FAIL midreset strobe before: got %b want 1", mem_Write_Enable);
    end
    reset = 1'b0;
    #1;
    model_reset();
    tests++;
    if (dut_obs !== '0) begin
      fails++; $display("FAIL midreset outputs: got %h want 0", dut_obs);
    end
    @(negedge clk);
    vertical_Pulse = 1'b0; horizontal_Pulse = 1'b0;
    reset = 1'b1;
    drive(1, 0, '0);
    for (int k = 0; k < TOTAL; k++) begin
      drive(1, 1, rand_word());
      if (k == 0) begin
        tests++;
        if (mem_Address !== AW'(12)) begin
          fails++; $display("FAIL midreset first addr: got %0d want 12", mem_Address);
        end
      end
      tests++;
      if (dut_obs !== mdl_obs) begin
        fails++; $display("FAIL midreset beat %0d: got %h want %h", k, dut_obs, mdl_obs);
      end
    end
  endtask

  task automatic test_random();
    logic v = 1'b0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) v = ~v;
      drive(v, 1'($urandom_range(0, 3) != 0), rand_word());
      tests++;
      if (dut_obs !== mdl_obs) begin
        fails++; $display("FAIL random cycle %0d: got %h want %h", i, dut_obs, mdl_obs);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    vertical_Pulse = 1'b0; horizontal_Pulse = 1'b0;
    {data_R_Odd, data_G_Odd, data_B_Odd, data_R_Even, data_G_Even, data_B_Even} = '0;
    model_reset();
    test_reset();
    test_full_frame();
    test_gapped();
    test_data_packing();
    test_overrun();
    test_short_frame();
    test_sof_with_beat();
    test_complete_with_sof();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/write_data.md
Name: write_data

Overview:
- Receive-side counterpart of the image streamer: accepts the even/odd RGB pixel-pair stream, framed by vertical/horizontal pulses, and writes each pair into a frame memory.
- Rows are written in bottom-up order, matching the stored picture's row layout, so a captured frame can be dumped back to a hex/BMP image.
- Sits between the threshold/processing datapath output and the frame buffer. Reports frame completion and framing errors.

Parameters:
- IMAGE_WIDTH, 768, pixels per row; must be even.
- IMAGE_HEIGHT, 512, rows per frame.
- ADDRESS_WIDTH, 18, memory word address width; must hold IMAGE_WIDTH*IMAGE_HEIGHT/2 - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- vertical_Pulse  input  1  frame-active; a rising edge starts a frame.
- horizontal_Pulse  input  1  pair-valid; one pixel pair is accepted per cycle while high.
- data_R_Even, data_G_Even, data_B_Even  input  8 each  even-pixel RGB.
- data_R_Odd, data_G_Odd, data_B_Odd  input  8 each  odd-pixel RGB.
- mem_Write_Enable  output  1  one-cycle write strobe.
- mem_Address  output  ADDRESS_WIDTH  word address.
- mem_Data  output  48  word {R_Odd,G_Odd,B_Odd,R_Even,G_Even,B_Even}, MSB first.
- done_Flag  output  1  frame complete; sticky.
- overrun_Error  output  1  pairs received after frame complete; sticky.
- short_Frame_Error  output  1  new frame started before completion; sticky.

Behaviour:
- Reset (async, low): all outputs 0, column/row counters 0, state IDLE, vertical_Pulse edge register 0.
- Definitions: PAIRS_PER_ROW = IMAGE_WIDTH/2. A beat is a cycle with horizontal_Pulse=1 in state RECEIVE.
- Start-of-frame (sof) = vertical_Pulse rising edge, detected from a registered copy of vertical_Pulse.

State machine:
- IDLE: waits for sof, then goes to RECEIVE. Beats are ignored here.
- RECEIVE: each beat produces a write.
  - Column counter increments on each beat.
  - When the column reaches PAIRS_PER_ROW-1, the column clears and the row increments.
  - Last beat (row = IMAGE_HEIGHT-1, column = PAIRS_PER_ROW-1): go to DONE.
- DONE: done_Flag=1. Further beats cause no write and set overrun_Error.
- sof in DONE: go to RECEIVE; clear done_Flag, overrun_Error, short_Frame_Error and the counters.

Address and data:
- mem_Address = (IMAGE_HEIGHT-1-row)*PAIRS_PER_ROW + column, computed in ADDRESS_WIDTH bits.
- Latency: exactly 1 cycle. mem_Write_Enable/mem_Address/mem_Data are registered in the cycle after the beat.
- mem_Data/mem_Address hold their last value when no write occurs.
- horizontal_Pulse gaps mid-row are allowed; counters hold during gaps.
- vertical_Pulse falling mid-frame has no effect; only the pair count ends a frame.

Boundary conditions:
- sof during RECEIVE (frame incomplete): set short_Frame_Error, zero counters, remain in RECEIVE, clear done_Flag.
- sof and a beat in the same cycle: sof takes priority. That beat is written as row 0, column 0 of the new frame, and the counters advance to column 1.
- Completing beat and sof in the same cycle: the beat is written, then the FSM goes to RECEIVE with counters cleared and done_Flag 0; no short_Frame_Error.
- Reset mid-frame: immediate return to IDLE. The pending write strobe is dropped.

Test Plan:
- Use IMAGE_WIDTH=8, IMAGE_HEIGHT=4 (4 pairs/row, 16/frame) unless noted.
- Full frame: sof, 16 consecutive beats with data=k -> 16 strobes. Addresses 12,13,14,15,8,…,3, each 1 cycle after its beat. done_Flag rises the cycle after beat 16.
- Gapped stream: horizontal_Pulse toggled 1/0 for 16 beats -> same address sequence with no skips, strobes only after high cycles; done_Flag after beat 16.
- Data packing: R_Even=0x11, G_Even=0x22, B_Even=0x33, R_Odd=0x44, G_Odd=0x55, B_Odd=0x66 -> mem_Data=0x445566112233.
- Overrun: 17 beats -> 16 writes, overrun_Error=1, done_Flag=1. A new sof clears both flags.
- Short frame: sof, 6 beats, sof, 16 beats -> short_Frame_Error=1. Second-frame first address is 12; done_Flag after its 16th beat.
- Reset mid-frame: async reset asserted after beat 5, released, sof, 16 beats -> all outputs 0 during reset; next frame starts at address 12.
